// File: rtl/shift_register_scheduler.sv
// Two-port round-robin arbiter and sequencer for a WIDTH-bit parallel-load shift register.
// Each grant runs one load cycle, WIDTH shift cycles and a one-cycle Done acknowledge.
module shift_register_scheduler #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [1:0]       Req,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   output logic [1:0]       Grant,
   output logic             Load,
   output logic             Shift,
   output logic [WIDTH-1:0] D,
   output logic             Busy,
   output logic             Done,
   output logic             DoneId
);

   localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } state_t;

   state_t           state, stateNext;
   logic [1:0]       grantReg, grantNext;
   logic             loadReg, loadNext;
   logic             shiftReg, shiftNext;
   logic [WIDTH-1:0] dReg, dNext;
   logic             busyReg, busyNext;
   logic             doneReg, doneNext;
   logic             doneIdReg, doneIdNext;
   logic [CW-1:0]    cnt, cntNext;
   logic             lastServed, lastNext;
   logic             pick;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         grantReg   <= '0;
         loadReg    <= 1'b0;
         shiftReg   <= 1'b0;
         dReg       <= '0;
         busyReg    <= 1'b0;
         doneReg    <= 1'b0;
         doneIdReg  <= 1'b0;
         cnt        <= '0;
         lastServed <= 1'b1;
      end else begin
         state      <= stateNext;
         grantReg   <= grantNext;
         loadReg    <= loadNext;
         shiftReg   <= shiftNext;
         dReg       <= dNext;
         busyReg    <= busyNext;
         doneReg    <= doneNext;
         doneIdReg  <= doneIdNext;
         cnt        <= cntNext;
         lastServed <= lastNext;
      end
   end

   always_comb begin
      stateNext  = state;
      grantNext  = grantReg;
      loadNext   = 1'b0;
      shiftNext  = 1'b0;
      dNext      = dReg;
      busyNext   = busyReg;
      doneNext   = 1'b0;
      doneIdNext = doneIdReg;
      cntNext    = cnt;
      lastNext   = lastServed;
      // On a tie the requester that was not served last wins.
      pick       = (Req == 2'b11) ? ~lastServed : Req[1];
      unique case (state)
         IDLE: begin
            grantNext = '0;
            busyNext  = 1'b0;
            if (Req != 2'b00) begin
               stateNext = LOAD;
               grantNext = pick ? 2'b10 : 2'b01;
               dNext     = pick ? D1 : D0;
               loadNext  = 1'b1;
               busyNext  = 1'b1;
               lastNext  = pick;
            end
         end
         LOAD: begin
            stateNext = SHIFT;
            shiftNext = 1'b1;
            cntNext   = CW'(WIDTH - 1);
         end
         SHIFT: begin
            if (cnt == '0) begin
               stateNext  = DONE;
               doneNext   = 1'b1;
               doneIdNext = grantReg[1];
            end else begin
               cntNext   = cnt - CW'(1);
               shiftNext = 1'b1;
            end
         end
         DONE: begin
            stateNext = IDLE;
            grantNext = '0;
            busyNext  = 1'b0;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign Grant  = grantReg;
   assign Load   = loadReg;
   assign Shift  = shiftReg;
   assign D      = dReg;
   assign Busy   = busyReg;
   assign Done   = doneReg;
   assign DoneId = doneIdReg;

endmodule
